// File: rtl/urv_ahb_arbiter.sv
// urv_ahb_arbiter: two-port AHB-Lite master arbiter sharing one bus between fetch and load/store
module urv_ahb_arbiter #(
    parameter int unsigned FETCH_MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_gnt_o,
    output logic        f_rvalid_o,
    output logic [31:0] f_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [1:0]  d_size_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_done_o,
    output logic [31:0] d_rdata_o,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY
);
    localparam logic [3:0] MAX_WAIT = 4'(FETCH_MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       dp_valid;
    logic       dp_owner;
    logic       dp_write;
    logic       starve;
    logic       sel_d;
    logic       sel_f;

    // Address-phase selection and bus/grant/completion muxing
    always_comb begin
        starve     = f_req_i & (wait_cnt == MAX_WAIT);
        sel_d      = d_req_i & ~starve;
        sel_f      = f_req_i & ~sel_d;
        HTRANS     = (sel_d | sel_f) ? 2'b10 : 2'b00;
        HADDR      = sel_d ? d_addr_i : (sel_f ? f_addr_i : 32'h0);
        HWRITE     = sel_d & d_we_i;
        HSIZE      = sel_d ? {1'b0, d_size_i} : 3'b010;
        d_gnt_o    = sel_d & HREADY;
        f_gnt_o    = sel_f & HREADY;
        f_rvalid_o = dp_valid & ~dp_owner & HREADY;
        d_done_o   = dp_valid & (dp_owner | dp_write) & HREADY;
        f_rdata_o  = HRDATA;
        d_rdata_o  = HRDATA;
    end

    // Data-phase ownership and store data advance only when the bus is ready
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dp_valid <= 1'b0;
            dp_owner <= 1'b0;
            dp_write <= 1'b0;
            HWDATA   <= 32'h0;
        end else if (HREADY) begin
            dp_valid <= sel_d | sel_f;
            dp_owner <= sel_d;
            dp_write <= sel_d & d_we_i;
            if (sel_d && d_we_i)
                HWDATA <= d_wdata_i;
        end
    end

    // Count data wins over a pending fetch so fetch cannot starve
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            wait_cnt <= 4'h0;
        else if (!f_req_i || f_gnt_o)
            wait_cnt <= 4'h0;
        else if (d_gnt_o && wait_cnt != MAX_WAIT)
            wait_cnt <= wait_cnt + 4'h1;
    end
endmodule

// File: tb/tb_urv_ahb_arbiter.sv
// tb_urv_ahb_arbiter: scoreboard-based self-checking bench for urv_ahb_arbiter
module tb_urv_ahb_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        f_req_i = 1'b0;
    logic [31:0] f_addr_i = 32'h0;
    logic        f_gnt_o, f_rvalid_o;
    logic [31:0] f_rdata_o;
    logic        d_req_i = 1'b0;
    logic        d_we_i = 1'b0;
    logic [1:0]  d_size_i = 2'd2;
    logic [31:0] d_addr_i = 32'h0;
    logic [31:0] d_wdata_i = 32'h0;
    logic        d_gnt_o, d_done_o;
    logic [31:0] d_rdata_o;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HRDATA = 32'h0;
    logic        HREADY = 1'b1;

    int total = 0;
    int bad = 0;
    logic [32:0] sb_q[$];
    logic [32:0] exp_c;

    urv_ahb_arbiter #(.FETCH_MAX_WAIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
        .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
        .d_done_o(d_done_o), .d_rdata_o(d_rdata_o),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
    );

    always #5 clk_i = ~clk_i;

    // drive all inputs just after the falling edge, then settle before sampling
    task automatic drive(input logic rst, input logic freq, input logic [31:0] faddr,
                         input logic dreq, input logic dwe, input logic [1:0] dsize,
                         input logic [31:0] daddr, input logic [31:0] dwdata,
                         input logic hready, input logic [31:0] hrdata);
        @(negedge clk_i);
        rst_i = rst; f_req_i = freq; f_addr_i = faddr;
        d_req_i = dreq; d_we_i = dwe; d_size_i = dsize; d_addr_i = daddr; d_wdata_i = dwdata;
        HREADY = hready; HRDATA = hrdata;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h0);
        total++;
        if ({HTRANS, HADDR, HSIZE, HWRITE, HWDATA} !== {2'b00, 32'h0, 3'b010, 1'b0, 32'h0}) begin
            bad++; $display("FAIL reset_bus: got htrans=%h haddr=%h hsize=%h hwrite=%b hwdata=%h", HTRANS, HADDR, HSIZE, HWRITE, HWDATA);
        end
        total++;
        if ({f_gnt_o, d_gnt_o, f_rvalid_o, d_done_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl: got %b want 0000", {f_gnt_o, d_gnt_o, f_rvalid_o, d_done_o});
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h0);
        total++;
        if ({HTRANS, f_rvalid_o, d_done_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_release: got %b want 0000", {HTRANS, f_rvalid_o, d_done_o});
        end
    endtask

    task automatic test_single_fetch();
        drive(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h0);
        total++;
        if ({f_gnt_o, d_gnt_o, HTRANS, HADDR, HSIZE, HWRITE, f_rvalid_o} !== {1'b1, 1'b0, 2'b10, 32'h100, 3'b010, 1'b0, 1'b0}) begin
            bad++; $display("FAIL fetch_addr: got gnt=%b htrans=%h haddr=%h hsize=%h hwrite=%b", f_gnt_o, HTRANS, HADDR, HSIZE, HWRITE);
        end
        sb_q.push_back({1'b0, 32'hDEADBEEF});
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF);
        exp_c = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h1_FFFF_FFFF;
        total++;
        if ({f_rvalid_o, d_done_o, f_rdata_o} !== {~exp_c[32], exp_c[32], exp_c[31:0]}) begin
            bad++; $display("FAIL fetch_done: got rvalid=%b done=%b rdata=%h want %h", f_rvalid_o, d_done_o, f_rdata_o, exp_c);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h0);
        total++;
        if ({f_rvalid_o, HTRANS} !== 3'b000) begin
            bad++; $display("FAIL fetch_idle: got %b want 000", {f_rvalid_o, HTRANS});
        end
    endtask

    task automatic test_store_wait();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'd0, 32'h203, 32'hAA000000, 1'b1, 32'h0);
        total++;
        if ({d_gnt_o, HTRANS, HADDR, HSIZE, HWRITE, HWDATA} !== {1'b1, 2'b10, 32'h203, 3'b000, 1'b1, 32'h0}) begin
            bad++; $display("FAIL store_addr: got gnt=%b haddr=%h hsize=%h hwrite=%b hwdata=%h", d_gnt_o, HADDR, HSIZE, HWRITE, HWDATA);
        end
        sb_q.push_back({1'b1, 32'h0});
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, (i == 3), 32'h0);
            total++;
            if (HWDATA !== 32'hAA000000) begin
                bad++; $display("FAIL store_hwdata_c%0d: got %h want aa000000", i, HWDATA);
            end
            if (i < 3) begin
                total++;
                if (d_done_o !== 1'b0) begin
                    bad++; $display("FAIL store_wait_c%0d: done=%b want 0", i, d_done_o);
                end
            end else begin
                exp_c = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h0_FFFF_FFFF;
                total++;
                if ({d_done_o, f_rvalid_o, d_rdata_o} !== {exp_c[32], ~exp_c[32], exp_c[31:0]}) begin
                    bad++; $display("FAIL store_done: got done=%b rvalid=%b want %h", d_done_o, f_rvalid_o, exp_c);
                end
            end
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h0);
        total++;
        if ({d_done_o, HWDATA} !== {1'b0, 32'hAA000000}) begin
            bad++; $display("FAIL store_after: got done=%b hwdata=%h", d_done_o, HWDATA);
        end
    endtask

    task automatic test_contention();
        logic want_f;
        for (int i = 0; i < 11; i++) begin
            want_f = (i % 5) == 4;
            drive(1'b1, (i < 10), 32'h400, (i < 10), 1'b0, 2'd2, 32'h800, 32'h0, 1'b1, 32'hC0000000 + 32'(i));
            if (i > 0) begin
                exp_c = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h0_FFFF_FFFF;
                total++;
                if ({d_done_o, f_rvalid_o, HRDATA} !== {exp_c[32], ~exp_c[32], exp_c[31:0]}) begin
                    bad++; $display("FAIL cont_done_%0d: got done=%b rvalid=%b data=%h want %h", i, d_done_o, f_rvalid_o, HRDATA, exp_c);
                end
            end
            if (i < 10) begin
                total++;
                if ({f_gnt_o, d_gnt_o, HADDR} !== {want_f, ~want_f, want_f ? 32'h400 : 32'h800}) begin
                    bad++; $display("FAIL cont_gnt_%0d: got f=%b d=%b haddr=%h want f=%b", i, f_gnt_o, d_gnt_o, HADDR, want_f);
                end
                sb_q.push_back({~want_f, 32'hC0000000 + 32'(i + 1)});
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 32'h0);
        total++;
        if ({d_gnt_o, HADDR, HWRITE} !== {1'b1, 32'h10, 1'b0}) begin
            bad++; $display("FAIL b2b_gnt1: got gnt=%b haddr=%h", d_gnt_o, HADDR);
        end
        sb_q.push_back({1'b1, 32'h11111111});
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h14, 32'h0, 1'b1, 32'h11111111);
        exp_c = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h0_FFFF_FFFF;
        total++;
        if ({d_gnt_o, HADDR, d_done_o, d_rdata_o} !== {1'b1, 32'h14, exp_c[32], exp_c[31:0]}) begin
            bad++; $display("FAIL b2b_overlap: got gnt=%b haddr=%h done=%b rdata=%h", d_gnt_o, HADDR, d_done_o, d_rdata_o);
        end
        sb_q.push_back({1'b1, 32'h22222222});
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h22222222);
        exp_c = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h0_FFFF_FFFF;
        total++;
        if ({d_gnt_o, d_done_o, d_rdata_o} !== {1'b0, exp_c[32], exp_c[31:0]}) begin
            bad++; $display("FAIL b2b_done2: got gnt=%b done=%b rdata=%h", d_gnt_o, d_done_o, d_rdata_o);
        end
    endtask

    task automatic test_stall_addr();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h30, 32'h0, 1'b0, 32'h0);
            total++;
            if ({d_gnt_o, HTRANS, HADDR, d_done_o} !== {1'b0, 2'b10, 32'h30, 1'b0}) begin
                bad++; $display("FAIL stall_c%0d: got gnt=%b htrans=%h haddr=%h", i, d_gnt_o, HTRANS, HADDR);
            end
        end
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h30, 32'h0, 1'b1, 32'h0);
        total++;
        if (d_gnt_o !== 1'b1) begin
            bad++; $display("FAIL stall_gnt: got %b want 1", d_gnt_o);
        end
        sb_q.push_back({1'b1, 32'h33333333});
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h33333333);
        exp_c = (sb_q.size() != 0) ? sb_q.pop_front() : 33'h0_FFFF_FFFF;
        total++;
        if ({d_done_o, d_rdata_o} !== exp_c) begin
            bad++; $display("FAIL stall_done: got done=%b rdata=%h want %h", d_done_o, d_rdata_o, exp_c);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 32'h40, 32'h0, 1'b1, 32'h0);
        total++;
        if (d_gnt_o !== 1'b1) begin
            bad++; $display("FAIL rmid_gnt: got %b want 1", d_gnt_o);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 32'h0);
        total++;
        if ({HWDATA, HTRANS, d_done_o} !== {32'h0, 2'b00, 1'b0}) begin
            bad++; $display("FAIL rmid_in_reset: got hwdata=%h htrans=%h done=%b", HWDATA, HTRANS, d_done_o);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 32'h0);
            total++;
            if ({d_done_o, f_rvalid_o, HTRANS, HWDATA} !== {1'b0, 1'b0, 2'b00, 32'h0}) begin
                bad++; $display("FAIL rmid_after_c%0d: got done=%b rvalid=%b htrans=%h hwdata=%h", i, d_done_o, f_rvalid_o, HTRANS, HWDATA);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_wait();
        test_contention();
        test_back_to_back();
        test_stall_addr();
        test_reset_mid();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
